ibpl_input_conditioner: RTL and testbench
=========================================

Name: ibpl_input_conditioner

Overview:
- Per-channel input conditioning stage directly downstream of the interbackplane cardlet's internal_in bus. Feeds the blackbox core.
- Chain per channel: synchronise raw backplane inputs → glitch-filter (debounce) → edge pulses → stretched activity flag.
- The activity flag drives the cardlet's input_act LED vector; clean levels and edge pulses go to the core.

Parameters:
- N_CH, 8, number of input channels; matches internal_in width.
- DEB_W, 16, width of debounce threshold and per-channel counter.
- ACT_W, 24, width of activity-stretch counter (~134 ms at 125 MHz when full).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- raw_in  in  N_CH  unsynchronised inputs from cardlet internal_in
- input_enable  in  N_CH  per-channel enable, quasi-static config
- deb_cycles  in  DEB_W  stable cycles required before a level change is accepted; 0 = bypass
- act_len  in  ACT_W  activity-stretch length in cycles; 0 = activity flag never asserts
- clean_out  out  N_CH  debounced level
- rise_pulse  out  N_CH  one-cycle pulse on accepted 0→1
- fall_pulse  out  N_CH  one-cycle pulse on accepted 1→0
- input_act  out  N_CH  stretched activity indicator

Behaviour:
- Reset:
  - All sync flops, clean_out, rise_pulse, fall_pulse, input_act, debounce counters and stretch counters = 0.
  - FSM state = STABLE.
- Reset asserted mid-qualification or mid-stretch aborts immediately. No pulses are emitted in the cycle after reset deasserts.
- Synchroniser:
  - 2-FF per channel, always running, independent of input_enable.
  - Output of the second stage is sync[i].
- Per-channel FSM, states STABLE and QUALIFY:
  - STABLE: cnt = 0.
    - If sync[i] != clean_out[i] and deb_cycles == 0: toggle clean_out now; stay STABLE.
    - Else if sync[i] != clean_out[i]: go QUALIFY, cnt = 1.
  - QUALIFY:
    - If sync[i] == clean_out[i] (glitch): go STABLE, cnt = 0, no output change.
    - Else if cnt >= deb_cycles: toggle clean_out, go STABLE, cnt = 0.
    - Else cnt = cnt + 1. Saturates at all-ones; no wrap.
  - The comparison is >=, so lowering deb_cycles mid-qualification accepts on the next cycle. Raising it extends qualification.
- Latency:
  - raw edge to clean_out change = 2 (sync) + deb_cycles + 1 cycles for deb_cycles ≥ 1.
  - 3 cycles for deb_cycles = 0.
  - Pulses to deb_cycles ≥ 1 must be at least deb_cycles+1 cycles wide to pass.
- Edge pulses:
  - rise_pulse[i] / fall_pulse[i] are registered and asserted the cycle after clean_out toggles, for exactly 1 cycle.
  - Never both in the same cycle.
- Disable:
  - While input_enable[i] = 0: FSM forced STABLE, cnt = 0, clean_out[i] = 0, stretch counter cleared, input_act[i] = 0.
  - Disabling while clean_out = 1 emits no fall_pulse. The forced clear is not an edge.
  - On re-enable with sync = 1: normal qualification, then rise_pulse.
- Activity stretch:
  - On rise_pulse or fall_pulse, the stretch counter loads act_len.
  - Otherwise it decrements while nonzero.
  - input_act[i] = (counter != 0), registered.
  - A new edge during stretch reloads the counter (retrigger).
  - An edge in the same cycle as the counter reaching 1 reloads it; no gap in input_act.
- Channels are fully independent; no shared arbitration.

Decomposition:
- Shared package ibpl_pkg:
  - State typedef (STABLE, QUALIFY).
  - Default parameter constants IBPL_N_CH, IBPL_DEB_W, IBPL_ACT_W.
  - Used by this block and the cardlet wrapper.
- One sub-module, ibpl_in_chan: single-channel sync + FSM + edge + stretch.
- Top is a generate loop of N_CH instances plus fan-out of config.

Test Plan:
- Reset/bypass: rst for 5 cycles, deb_cycles=0, act_len=4; raw_in[0] 0→1 → clean_out[0]=1 exactly 3 cycles later; rise_pulse[0] one cycle after that; input_act[0] high 4 cycles.
- Glitch reject: deb_cycles=10; 8-cycle high pulse on raw_in[2] → no clean_out/pulse change. 11-cycle pulse → clean_out[2] rises at cycle 2+11 after raw edge, then fall_pulse after the low level qualifies.
- Retrigger: act_len=100; edges on ch1 at t=0 and t=50 → input_act[1] continuously high until ~t=150+latency, then low.
- Disable mid-high: ch3 clean_out=1, drop input_enable[3] → clean_out[3]=0 next cycle, no fall_pulse, input_act[3]=0. Re-enable with raw high → rise_pulse after deb_cycles+1.
- Threshold change: deb_cycles=1000, raw_in[4] held high 20 cycles into qualification, then set deb_cycles=5 → clean_out[4] toggles the next cycle.
- Reset mid-qualify: rst asserted while ch5 in QUALIFY → all outputs 0; after release with raw still high, rise qualifies from scratch (full 2+deb_cycles+1 latency).

Source files
------------

// File: rtl/ibpl_pkg.sv
// Shared definitions for the interbackplane input path: the default sizes
// and the per-channel conditioner state type.
package ibpl_pkg;

   localparam int IBPL_N_CH  = 8;
   localparam int IBPL_DEB_W = 16;
   localparam int IBPL_ACT_W = 24;

   typedef enum logic {
      STABLE  = 1'b0,
      QUALIFY = 1'b1
   } ibpl_state_e;

endpackage

// File: rtl/ibpl_in_chan.sv
// Single input channel: 2-FF synchroniser, debounce FSM, edge pulses and a
// retriggerable activity stretcher.
//
// state   | meaning
// --------+-----------------------------------------------------------
// STABLE  | synchronised input agrees with clean level; counter idle
// QUALIFY | input differs from clean level; counting stable cycles
module ibpl_in_chan
   import ibpl_pkg::*;
#(
   parameter int DEB_W = IBPL_DEB_W,
   parameter int ACT_W = IBPL_ACT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_raw,
   input  logic             i_enable,
   input  logic [DEB_W-1:0] i_deb_cycles,
   input  logic [ACT_W-1:0] i_act_len,
   output logic             o_clean,
   output logic             o_rise,
   output logic             o_fall,
   output logic             o_act
);

   logic             r_sync1;
   logic             r_sync2;
   ibpl_state_e      r_state;
   ibpl_state_e      w_state_nxt;
   logic [DEB_W-1:0] r_cnt;
   logic [DEB_W-1:0] w_cnt_nxt;
   logic             r_clean;
   logic             w_clean_nxt;
   logic             r_tog;
   logic             w_tog;
   logic             r_rise;
   logic             r_fall;
   logic [ACT_W-1:0] r_str;
   logic [ACT_W-1:0] w_str_nxt;
   logic             r_act;

   // Synchroniser runs regardless of enable so re-enable sees a settled level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce state, counter, clean level and the toggle marker for pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= STABLE;
         r_cnt   <= '0;
         r_clean <= 1'b0;
         r_tog   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_clean <= w_clean_nxt;
         r_tog   <= w_tog;
      end
   end

   // Next-state logic; a disabled channel is held cleared without a toggle event.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clean_nxt = r_clean;
      w_tog       = 1'b0;
      if (!i_enable) begin
         w_state_nxt = STABLE;
         w_cnt_nxt   = '0;
         w_clean_nxt = 1'b0;
      end else begin
         case (r_state)
            STABLE: begin
               w_cnt_nxt = '0;
               if (r_sync2 != r_clean) begin
                  if (i_deb_cycles == '0) begin
                     w_clean_nxt = ~r_clean;
                     w_tog       = 1'b1;
                  end else begin
                     w_state_nxt = QUALIFY;
                     w_cnt_nxt   = DEB_W'(1);
                  end
               end
            end
            QUALIFY: begin
               if (r_sync2 == r_clean) begin
                  w_state_nxt = STABLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt >= i_deb_cycles) begin
                  w_state_nxt = STABLE;
                  w_cnt_nxt   = '0;
                  w_clean_nxt = ~r_clean;
                  w_tog       = 1'b1;
               end else if (r_cnt != '1) begin
                  w_cnt_nxt = r_cnt + DEB_W'(1);
               end
            end
            default: begin
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Edge pulses one cycle after the clean level toggles; direction from the new level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= i_enable & r_tog &  r_clean;
         r_fall <= i_enable & r_tog & ~r_clean;
      end
   end

   // Stretch counter: reload on any edge pulse, otherwise count down to zero.
   always_comb begin
      w_str_nxt = r_str;
      if (!i_enable) begin
         w_str_nxt = '0;
      end else if (r_rise || r_fall) begin
         w_str_nxt = i_act_len;
      end else if (r_str != '0) begin
         w_str_nxt = r_str - ACT_W'(1);
      end
   end

   // Activity flag tracks the counter so a reload at count 1 leaves no gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_str <= '0;
         r_act <= 1'b0;
      end else begin
         r_str <= w_str_nxt;
         r_act <= (w_str_nxt != '0);
      end
   end

   assign o_clean = r_clean;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
   assign o_act   = r_act;

endmodule

// File: rtl/ibpl_input_conditioner.sv
// Conditions the cardlet internal_in bus: one independent channel per bit,
// sharing only the debounce and stretch configuration.
module ibpl_input_conditioner
   import ibpl_pkg::*;
#(
   parameter int N_CH  = IBPL_N_CH,
   parameter int DEB_W = IBPL_DEB_W,
   parameter int ACT_W = IBPL_ACT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  raw_in,
   input  logic [N_CH-1:0]  input_enable,
   input  logic [DEB_W-1:0] deb_cycles,
   input  logic [ACT_W-1:0] act_len,
   output logic [N_CH-1:0]  clean_out,
   output logic [N_CH-1:0]  rise_pulse,
   output logic [N_CH-1:0]  fall_pulse,
   output logic [N_CH-1:0]  input_act
);

   // One conditioner per input bit.
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ibpl_in_chan #(
         .DEB_W (DEB_W),
         .ACT_W (ACT_W)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .i_raw        (raw_in[g]),
         .i_enable     (input_enable[g]),
         .i_deb_cycles (deb_cycles),
         .i_act_len    (act_len),
         .o_clean      (clean_out[g]),
         .o_rise       (rise_pulse[g]),
         .o_fall       (fall_pulse[g]),
         .o_act        (input_act[g])
      );
   end

endmodule

// File: tb/tb_ibpl_input_conditioner.sv
// Directed bench for the input conditioner. Inputs change and outputs are
// sampled on the falling edge; expected cycle counts are hand-derived.
module tb_ibpl_input_conditioner;

   localparam int N_CH  = 8;
   localparam int DEB_W = 16;
   localparam int ACT_W = 24;

   logic             clk;
   logic             rst;
   logic [N_CH-1:0]  raw_in;
   logic [N_CH-1:0]  input_enable;
   logic [DEB_W-1:0] deb_cycles;
   logic [ACT_W-1:0] act_len;
   logic [N_CH-1:0]  clean_out;
   logic [N_CH-1:0]  rise_pulse;
   logic [N_CH-1:0]  fall_pulse;
   logic [N_CH-1:0]  input_act;

   int n_chk;
   int n_fail;

   ibpl_input_conditioner #(
      .N_CH  (N_CH),
      .DEB_W (DEB_W),
      .ACT_W (ACT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .raw_in       (raw_in),
      .input_enable (input_enable),
      .deb_cycles   (deb_cycles),
      .act_len      (act_len),
      .clean_out    (clean_out),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .input_act    (input_act)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gaps;
      int seen;
      n_chk        = 0;
      n_fail       = 0;
      rst          = 1'b1;
      raw_in       = '0;
      input_enable = '1;
      deb_cycles   = '0;
      act_len      = 24'd4;

      // Reset
      step(5);
      chk("rst_clean", 32'(clean_out), 32'h0);
      chk("rst_rise",  32'(rise_pulse), 32'h0);
      chk("rst_fall",  32'(fall_pulse), 32'h0);
      chk("rst_act",   32'(input_act), 32'h0);
      rst = 1'b0;
      step(2);

      // Bypass on ch0: clean after 3 cycles, pulse next, activity 4 cycles
      raw_in[0] = 1'b1;
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         if (k == 2) chk("byp_clean_k2", 32'(clean_out[0]), 32'h0);
         if (k == 3) chk("byp_clean_k3", 32'(clean_out[0]), 32'h1);
         if (k == 3) chk("byp_rise_k3", 32'(rise_pulse[0]), 32'h0);
         if (k == 4) chk("byp_rise_k4", 32'(rise_pulse[0]), 32'h1);
         if (k == 5) chk("byp_rise_k5", 32'(rise_pulse[0]), 32'h0);
         if (input_act[0]) seen++;
         if (k == 4) chk("byp_act_k4", 32'(input_act[0]), 32'h0);
         if (k == 9) chk("byp_act_k9", 32'(input_act[0]), 32'h0);
      end
      chk("byp_act_len", 32'(seen), 32'd4);

      // Glitch reject on ch2: 8-cycle pulse with deb=10 is swallowed
      deb_cycles = 16'd10;
      raw_in[2]  = 1'b1;
      seen = 0;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         if (k == 8) raw_in[2] = 1'b0;
         if (clean_out[2] || rise_pulse[2] || fall_pulse[2]) seen++;
      end
      chk("glitch_reject", 32'(seen), 32'h0);

      // 11-cycle pulse passes: rise at 2+11, fall after low qualifies
      raw_in[2] = 1'b1;
      for (int k = 1; k <= 27; k++) begin
         step(1);
         if (k == 11) raw_in[2] = 1'b0;
         if (k == 12) chk("deb_clean_k12", 32'(clean_out[2]), 32'h0);
         if (k == 13) chk("deb_clean_k13", 32'(clean_out[2]), 32'h1);
         if (k == 14) chk("deb_rise_k14", 32'(rise_pulse[2]), 32'h1);
         if (k == 23) chk("deb_clean_k23", 32'(clean_out[2]), 32'h1);
         if (k == 24) chk("deb_clean_k24", 32'(clean_out[2]), 32'h0);
         if (k == 24) chk("deb_fall_k24", 32'(fall_pulse[2]), 32'h0);
         if (k == 25) chk("deb_fall_k25", 32'(fall_pulse[2]), 32'h1);
         if (k == 26) chk("deb_fall_k26", 32'(fall_pulse[2]), 32'h0);
      end

      // Retrigger on ch1: edges at t=0 and t=50 keep activity up to t=154
      deb_cycles = 16'd0;
      act_len    = 24'd100;
      step(2);
      raw_in[1] = 1'b1;
      gaps = 0;
      for (int k = 1; k <= 160; k++) begin
         step(1);
         if (k == 4)  chk("retrig_act_k4", 32'(input_act[1]), 32'h0);
         if (k >= 5 && k <= 154 && !input_act[1]) gaps++;
         if (k == 54) chk("retrig_fall_k54", 32'(fall_pulse[1]), 32'h1);
         if (k == 155) chk("retrig_act_k155", 32'(input_act[1]), 32'h0);
         if (k == 50) raw_in[1] = 1'b0;
      end
      chk("retrig_gaps", 32'(gaps), 32'h0);

      // Disable ch3 while high: immediate clear, no fall pulse
      deb_cycles = 16'd3;
      act_len    = 24'd4;
      raw_in[3]  = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step(1);
         if (k == 6) chk("dis_clean_up", 32'(clean_out[3]), 32'h1);
         if (k == 7) chk("dis_rise_up", 32'(rise_pulse[3]), 32'h1);
      end
      chk("dis_act_pre", 32'(input_act[3]), 32'h1);
      input_enable[3] = 1'b0;
      step(1);
      chk("dis_clean", 32'(clean_out[3]), 32'h0);
      chk("dis_act", 32'(input_act[3]), 32'h0);
      seen = 0;
      for (int k = 1; k <= 4; k++) begin
         if (fall_pulse[3] || rise_pulse[3] || input_act[3]) seen++;
         step(1);
      end
      chk("dis_no_fall", 32'(seen), 32'h0);
      input_enable[3] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         if (k == 3) chk("reen_clean_k3", 32'(clean_out[3]), 32'h0);
         if (k == 4) chk("reen_clean_k4", 32'(clean_out[3]), 32'h1);
         if (k == 5) chk("reen_rise_k5", 32'(rise_pulse[3]), 32'h1);
      end

      // Threshold lowered mid-qualification on ch4 accepts next cycle
      deb_cycles = 16'd1000;
      raw_in[4]  = 1'b1;
      step(22);
      chk("thr_clean_pre", 32'(clean_out[4]), 32'h0);
      deb_cycles = 16'd5;
      step(1);
      chk("thr_clean_post", 32'(clean_out[4]), 32'h1);
      step(1);
      chk("thr_rise", 32'(rise_pulse[4]), 32'h1);

      // Reset while ch5 qualifies, then full requalification
      deb_cycles = 16'd10;
      raw_in[5]  = 1'b1;
      step(6);
      rst = 1'b1;
      step(1);
      chk("rstq_clean", 32'(clean_out), 32'h0);
      chk("rstq_act", 32'(input_act), 32'h0);
      chk("rstq_rise", 32'(rise_pulse), 32'h0);
      step(1);
      rst = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step(1);
         if (k == 1)  chk("rstq_pulse_k1", 32'(rise_pulse | fall_pulse), 32'h0);
         if (k == 12) chk("rstq_clean_k12", 32'(clean_out[5]), 32'h0);
         if (k == 13) chk("rstq_clean_k13", 32'(clean_out[5]), 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
